regfile_wr_sched: RTL and testbench

//  Write scheduler and init sequencer for the 2W BRAM register file. Shares the

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_wr_sched_if.sv | 31 +++
 rtl/regfile_wr_arb.sv | 51 +++++
 rtl/regfile_wr_sched.sv | 123 ++++++++++++
 tb/tb_regfile_wr_sched.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file write scheduler.
// Holds the scheduler state encoding and the address-width helper.
package regfile_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_NUM_WORDS  = 32;
  localparam int RF_NUM_REQ    = 3;

  // Address width for a given depth; never narrower than one bit.
  function automatic int addr_width(input int num_words);
    return (num_words > 2) ? $clog2(num_words) : 1;
  endfunction

  localparam int RF_AW = addr_width(RF_NUM_WORDS);

  typedef logic [0:0] sched_state_e;
  localparam sched_state_e INIT = 1'b0;
  localparam sched_state_e RUN  = 1'b1;

endpackage

// File: rtl/regfile_wr_sched_if.sv
// Requester-side handshake and regfile write-port bundle for regfile_wr_sched.
// master = requesters/regfile side, slave = the scheduler.
interface regfile_wr_sched_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_WORDS  = RF_NUM_WORDS,
  parameter int NUM_REQ    = RF_NUM_REQ
);
  localparam int AW = addr_width(NUM_WORDS);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][AW-1:0]         req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;

  logic [1:0]                         rf_we;
  logic [1:0][AW-1:0]                 rf_waddr;
  logic [1:0][DATA_WIDTH-1:0]         rf_wdata;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/regfile_wr_arb.sv
// Combinational two-grant picker: g0 is the lowest-index valid requester,
// g1 the next valid requester targeting a different address than g0.
module regfile_wr_arb #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 5
) (
  input  logic [NUM_REQ-1:0]         valid_i,
  input  logic [NUM_REQ-1:0][AW-1:0] addr_i,
  output logic [NUM_REQ-1:0]         g0_oh_o,
  output logic [NUM_REQ-1:0]         g1_oh_o,
  output logic                       g0_vld_o,
  output logic                       g1_vld_o
);

  logic [NUM_REQ-1:0] g0_oh;
  logic [NUM_REQ-1:0] g1_oh;
  logic               g0_vld;
  logic               g1_vld;
  logic [AW-1:0]      g0_addr;

  always_comb begin
    // NOTE: every variable gets a default before the loops so no path leaves it unassigned (no latch).
    g0_oh   = '0;
    g1_oh   = '0;
    g0_vld  = 1'b0;
    g1_vld  = 1'b0;
    g0_addr = '0;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (valid_i[i] && !g0_vld) begin
        g0_oh[i] = 1'b1;
        g0_vld   = 1'b1;
        g0_addr  = addr_i[i];
      end
    end

    // Any valid index other than g0 is already above g0, since g0 is the lowest.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (valid_i[i] && g0_vld && !g0_oh[i] && !g1_vld && (addr_i[i] != g0_addr)) begin
        g1_oh[i] = 1'b1;
        g1_vld   = 1'b1;
      end
    end
  end

  assign g0_oh_o  = g0_oh;
  assign g1_oh_o  = g1_oh;
  assign g0_vld_o = g0_vld;
  assign g1_vld_o = g1_vld;

endmodule

// File: rtl/regfile_wr_sched.sv
// Write scheduler and zero-fill sequencer for the two-write-port regfile.
// Holds the INIT/RUN FSM, fill pointer and registered write-port outputs.
module regfile_wr_sched
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH    = RF_DATA_WIDTH,
  parameter int NUM_WORDS     = RF_NUM_WORDS,
  parameter int NUM_REQ       = RF_NUM_REQ,
  parameter bit ZERO_REG_ZERO = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             init_req_i,
  output logic             init_done_o,
  regfile_wr_sched_if.slave bus
);

  localparam int            AW        = addr_width(NUM_WORDS);
  localparam logic [AW-1:0] LAST_PAIR = AW'(NUM_WORDS - 2);

  typedef struct packed {
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] data;
  } wreq_t;

  typedef struct packed {
    logic                  we;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] data;
  } wport_t;

  sched_state_e   state_q, state_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  wport_t [1:0]   port_q, port_d;

  logic [NUM_REQ-1:0] g0_oh, g1_oh;
  logic               g0_vld, g1_vld;
  wreq_t              g0_req, g1_req;

  regfile_wr_arb #(
    .NUM_REQ (NUM_REQ),
    .AW      (AW)
  ) u_arb (
    .valid_i  (bus.req_valid),
    .addr_i   (bus.req_addr),
    .g0_oh_o  (g0_oh),
    .g1_oh_o  (g1_oh),
    .g0_vld_o (g0_vld),
    .g1_vld_o (g1_vld)
  );

  function automatic logic drop_write(input logic [AW-1:0] addr);
    return ZERO_REG_ZERO && (addr == '0);
  endfunction

  always_comb begin
    g0_req = '0;
    g1_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g0_oh[i]) g0_req = '{addr: bus.req_addr[i], data: bus.req_data[i]};
      if (g1_oh[i]) g1_req = '{addr: bus.req_addr[i], data: bus.req_data[i]};
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    port_d        = port_q;
    port_d[0].we  = 1'b0;
    port_d[1].we  = 1'b0;
    bus.req_ready = '0;

    case (state_q)
      INIT: begin
        port_d[0] = '{we: 1'b1, addr: ptr_q,            data: '0};
        port_d[1] = '{we: 1'b1, addr: ptr_q + AW'(1),   data: '0};
        if (ptr_q == LAST_PAIR) begin
          state_d = RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(2);
        end
      end

      default: begin
        if (init_req_i) begin
          state_d = INIT;
          ptr_d   = '0;
        end else begin
          bus.req_ready = g0_oh | g1_oh;
          // Writes to x0 still consume their slot; only the strobe is suppressed.
          if (g0_vld) port_d[0] = '{we: !drop_write(g0_req.addr), addr: g0_req.addr, data: g0_req.data};
          if (g1_vld) port_d[1] = '{we: !drop_write(g1_req.addr), addr: g1_req.addr, data: g1_req.data};
        end
      end
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so all flops sample pre-edge values.
  // NOTE: the regfile array itself is never reset; the INIT fill is what clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT;
      ptr_q   <= '0;
      port_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      port_q  <= port_d;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      bus.rf_we[p]    = port_q[p].we;
      bus.rf_waddr[p] = port_q[p].addr;
      bus.rf_wdata[p] = port_q[p].data;
    end
  end

  assign init_done_o = (state_q == RUN);

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched (32 words, 3 requesters, x0 writes dropped).
// A small regfile model follows the rf_* ports to check final contents.
module tb_regfile_wr_sched;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int NW = 32;
  localparam int NR = 3;

  logic clk;
  logic rst_i;
  logic init_req;
  logic init_done;

  int vectors;
  int miscompares;

  logic [DW-1:0] mem [NW];

  regfile_wr_sched_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .NUM_REQ(NR)) bus ();

  regfile_wr_sched #(
    .DATA_WIDTH    (DW),
    .NUM_WORDS     (NW),
    .NUM_REQ       (NR),
    .ZERO_REG_ZERO (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .init_req_i  (init_req),
    .init_done_o (init_done),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      if (bus.rf_we[p] === 1'b1) mem[bus.rf_waddr[p]] <= bus.rf_wdata[p];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n fill cycles; pulses init_req during cycle pulse_k to show it is ignored.
  task automatic fill(input int n, input int pulse_k);
    for (int k = 0; k < n; k++) begin
      tick();
      init_req = 1'b0;
      check($sformatf("fill%0d_we", k),    bus.rf_we,       2'b11);
      check($sformatf("fill%0d_a0", k),    bus.rf_waddr[0], 2 * k);
      check($sformatf("fill%0d_a1", k),    bus.rf_waddr[1], 2 * k + 1);
      check($sformatf("fill%0d_d0", k),    bus.rf_wdata[0], 0);
      check($sformatf("fill%0d_d1", k),    bus.rf_wdata[1], 0);
      check($sformatf("fill%0d_done", k),  init_done,       (k == NW / 2 - 1) ? 1 : 0);
      if (k != NW / 2 - 1) check($sformatf("fill%0d_rdy", k), bus.req_ready, 0);
      if (k == pulse_k) init_req = 1'b1;
    end
  endtask

  task automatic set_req(input int i, input int addr, input logic [DW-1:0] data);
    bus.req_addr[i] = addr[4:0];
    bus.req_data[i] = data;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_i         = 1'b1;
    init_req      = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;

    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = 3'b111;
    set_req(0, 3, 32'hD0);
    set_req(1, 4, 32'hD1);
    set_req(2, 5, 32'hD2);
    #1;
    check("rst_we",    bus.rf_we,       0);
    check("rst_waddr", bus.rf_waddr,    0);
    check("rst_wdata", bus.rf_wdata,    0);
    check("rst_done",  init_done,       0);
    check("rst_ready", bus.req_ready,   0);
    rst_i = 1'b0;

    fill(NW / 2, -1);
    check("run_ready_3req", bus.req_ready, 3'b011);

    tick();
    check("pair_we",  bus.rf_we,       2'b11);
    check("pair_a0",  bus.rf_waddr[0], 3);
    check("pair_a1",  bus.rf_waddr[1], 4);
    check("pair_d0",  bus.rf_wdata[0], 32'hD0);
    check("pair_d1",  bus.rf_wdata[1], 32'hD1);
    bus.req_valid = 3'b100;
    #1;
    check("req2_ready", bus.req_ready, 3'b100);

    tick();
    check("req2_we",      bus.rf_we,       2'b01);
    check("req2_a0",      bus.rf_waddr[0], 5);
    check("req2_d0",      bus.rf_wdata[0], 32'hD2);
    check("req2_a1_hold", bus.rf_waddr[1], 4);
    check("req2_d1_hold", bus.rf_wdata[1], 32'hD1);
    bus.req_valid = 3'b000;
    #1;
    check("idle_ready", bus.req_ready, 0);

    tick();
    check("idle_we",      bus.rf_we,       0);
    check("idle_a0_hold", bus.rf_waddr[0], 5);

    set_req(0, 5, 32'hAAAA_0001);
    set_req(1, 5, 32'hBBBB_0002);
    bus.req_valid = 3'b011;
    #1;
    check("same_ready0", bus.req_ready, 3'b001);
    tick();
    check("same_we0", bus.rf_we,       2'b01);
    check("same_a0",  bus.rf_waddr[0], 5);
    check("same_dA",  bus.rf_wdata[0], 32'hAAAA_0001);
    bus.req_valid = 3'b010;
    #1;
    check("same_ready1", bus.req_ready, 3'b010);
    tick();
    check("same_we1", bus.rf_we,       2'b01);
    check("same_a1",  bus.rf_waddr[0], 5);
    check("same_dB",  bus.rf_wdata[0], 32'hBBBB_0002);
    bus.req_valid = 3'b000;
    tick();
    check("mem_x5", mem[5], 32'hBBBB_0002);
    check("mem_x3", mem[3], 32'hD0);
    check("mem_x4", mem[4], 32'hD1);

    set_req(0, 0, 32'hFF);
    bus.req_valid = 3'b001;
    #1;
    check("x0_ready", bus.req_ready, 3'b001);
    tick();
    check("x0_we", bus.rf_we, 0);
    bus.req_valid = 3'b000;
    tick();
    check("mem_x0", mem[0], 0);

    set_req(0, 7, 32'hC7);
    bus.req_valid = 3'b001;
    #1;
    check("pre_init_ready", bus.req_ready, 3'b001);
    tick();
    set_req(0, 9, 32'h99);
    init_req = 1'b1;
    #1;
    check("initreq_ready",   bus.req_ready,   0);
    check("initreq_we",      bus.rf_we,       2'b01);
    check("initreq_a0",      bus.rf_waddr[0], 7);
    check("initreq_d0",      bus.rf_wdata[0], 32'hC7);
    check("initreq_done",    init_done,       1);
    tick();
    init_req = 1'b0;
    #1;
    check("refill_done0", init_done,     0);
    check("refill_we0",   bus.rf_we,     0);
    check("refill_rdy0",  bus.req_ready, 0);
    fill(NW / 2, 5);
    check("refill_ready", bus.req_ready, 3'b001);
    tick();
    check("post_we", bus.rf_we,       2'b01);
    check("post_a0", bus.rf_waddr[0], 9);
    check("post_d0", bus.rf_wdata[0], 32'h99);
    bus.req_valid = 3'b000;
    tick();
    check("mem_x7_cleared", mem[7], 0);
    check("mem_x9",         mem[9], 32'h99);

    rst_i = 1'b1;
    #1;
    check("runrst_we",   bus.rf_we,    0);
    check("runrst_done", init_done,    0);
    rst_i = 1'b0;
    fill(7, -1);
    rst_i = 1'b1;
    #1;
    check("midrst_we",    bus.rf_we,    0);
    check("midrst_waddr", bus.rf_waddr, 0);
    check("midrst_wdata", bus.rf_wdata, 0);
    check("midrst_done",  init_done,    0);
    tick();
    rst_i = 1'b0;
    fill(NW / 2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
